ecc_apb_sequencer: RTL and testbench
====================================

ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, data/codeword width; AMBA_ADDR_WIDTH, 20, APB address width; AMBA_WORD, 32, APB data width; TIMEOUT_CYCLES, 1024, max wait for operation_done.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1, req_op in 2 (0 encode, 1 decode, 2 full, 3 illegal), req_data in DATA_WIDTH, req_width in 2 (codeword width code), req_noise in DATA_WIDTH: job request channel.
REQ-005 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_WIDTH, rsp_errors out 2, rsp_status out 2 (0 ok, 1 timeout, 2 illegal op): result channel.
REQ-006 SHALL have ports: PADDR out AMBA_ADDR_WIDTH, PWDATA out AMBA_WORD, PENABLE out 1, PSEL out 1, PWRITE out 1: APB master to ECC_ENC_DEC.
REQ-007 SHALL have ports: data_out in DATA_WIDTH, operation_done in 1, num_of_errors in 2: ECC_ENC_DEC result inputs; busy out 1, high whenever FSM is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
REQ-009 IDLE: req_ready=1; req_valid&&req_ready captures req_* into registers; legal op -> SETUP, op 3 -> RESP with rsp_status=2, no APB traffic.
REQ-010 SHALL issue four APB writes in order: DATA_IN (0x04, req_data), CODEWORD_WIDTH (0x08, req_width zero-extended), NOISE (0x0C, req_noise), CTRL (0x00, req_op zero-extended).
REQ-011 Each write: SETUP cycle PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid; ACCESS cycle PSEL=1, PENABLE=1, same addr/data; no PREADY, two cycles per write, back-to-back writes go ACCESS->SETUP.
REQ-012 Accept in cycle T -> SETUP of first write at T+1, CTRL ACCESS at T+8, WAIT_DONE from T+9.
REQ-013 Outside SETUP/ACCESS: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
REQ-014 operation_done SHALL be sampled only in WAIT_DONE; pulses in earlier states are ignored.
REQ-015 WAIT_DONE: operation_done=1 captures data_out, num_of_errors, status 0, -> RESP next cycle; same-cycle done and timeout expiry resolves to done.
REQ-016 Timeout counter SHALL clear on WAIT_DONE entry, increment each WAIT_DONE cycle; reaching TIMEOUT_CYCLES-1 without done -> RESP with rsp_status=1, rsp_data=0, rsp_errors=0.
REQ-017 RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready, then -> IDLE; req_ready=0 throughout.
REQ-018 Throughput: one job in flight; new request accepted earliest the cycle after response handshake.

Reset
REQ-019 rst=0 at a rising edge SHALL force IDLE from any state, including mid-APB-transfer, abandoning the job.
REQ-020 Reset values: req_ready=0 during reset then 1 in IDLE, rsp_valid=0, rsp_data=0, rsp_errors=0, rsp_status=0, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, busy=0, timeout counter=0.

Structure
REQ-021 Shared package SHALL hold register offsets (CTRL/DATA_IN/CODEWORD_WIDTH/NOISE), op encodings, status encodings, FSM state enum.
REQ-022 One sub-module ecc_apb_write_port SHALL implement the two-cycle APB write (start, addr, data in; done out); the sequencer owns ordering and timeout.

Verification
REQ-023 Encode req data=0x0000_00A5, width=0 -> APB writes 0x04/0xA5, 0x08/0, 0x0C/noise, 0x00/0 at T+1..T+8; done at T+12 -> rsp_valid at T+13 with data_out, status 0.
REQ-024 Decode with num_of_errors=2 at done -> rsp_errors=2, rsp_status=0.
REQ-025 No operation_done, TIMEOUT_CYCLES=16 -> rsp_status=1 at WAIT_DONE entry+16, rsp_data=0.
REQ-026 req_op=3 -> rsp_valid next cycle, rsp_status=2, PSEL never asserted.
REQ-027 rst=0 during NOISE ACCESS -> next cycle PSEL=0, busy=0; following job completes normally.
REQ-028 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, spurious operation_done ignored; handshake -> IDLE.

Source files
------------

// File: rtl/ecc_apb_sequencer_pkg.sv
// rtl/ecc_apb_sequencer_pkg.sv - shared register map, encodings and FSM states for the ECC APB sequencer
package ecc_apb_sequencer_pkg;

    localparam logic [7:0] REG_CTRL           = 8'h00;
    localparam logic [7:0] REG_DATA_IN        = 8'h04;
    localparam logic [7:0] REG_CODEWORD_WIDTH = 8'h08;
    localparam logic [7:0] REG_NOISE          = 8'h0C;

    typedef enum logic [1:0] {
        OP_ENCODE  = 2'd0,
        OP_DECODE  = 2'd1,
        OP_FULL    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_TIMEOUT = 2'd1,
        STATUS_ILLEGAL = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT_DONE,
        S_RESP
    } state_e;

    // Register written by each step of the four-write job sequence
    function automatic logic [7:0] write_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    return REG_DATA_IN;
            2'd1:    return REG_CODEWORD_WIDTH;
            2'd2:    return REG_NOISE;
            default: return REG_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/ecc_apb_write_port.sv
// rtl/ecc_apb_write_port.sv - two-cycle APB write master (SETUP then ACCESS), registered outputs
module ecc_apb_write_port #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  done,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata
);

    // start launches SETUP next cycle; SETUP always advances to ACCESS; a start seen in ACCESS chains the next write
    always_ff @(posedge clk) begin
        if (!rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (start) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= addr;
            pwdata  <= data;
        end else if (psel && !penable) begin
            penable <= 1'b1;
        end else begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end
    end

    assign done = psel & penable;

endmodule

// File: rtl/ecc_apb_sequencer.sv
// rtl/ecc_apb_sequencer.sv - job sequencer driving ECC_ENC_DEC over APB and collecting its result
module ecc_apb_sequencer
    import ecc_apb_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic [1:0]                 req_width,
    input  logic [DATA_WIDTH-1:0]      req_noise,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic [1:0]                 rsp_status,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PENABLE,
    output logic                       PSEL,
    output logic                       PWRITE,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       operation_done,
    input  logic [1:0]                 num_of_errors,
    output logic                       busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_e                state;
    logic [1:0]            idx;
    logic [1:0]            next_idx;
    logic [TW-1:0]         tcnt;
    logic [1:0]            op_q;
    logic [1:0]            width_q;
    logic [DATA_WIDTH-1:0] noise_q;

    logic                  wr_start;
    logic [7:0]            wr_offset;
    logic [AMBA_WORD-1:0]  wr_data;
    logic                  wr_done;

    // Pick the next write: the first one straight from the request bus, later ones from captured fields
    always_comb begin
        next_idx  = idx + 2'd1;
        wr_start  = 1'b0;
        wr_offset = REG_DATA_IN;
        wr_data   = AMBA_WORD'(req_data);
        if (state == S_IDLE) begin
            wr_start = req_valid && req_ready && (req_op != OP_ILLEGAL);
        end else if (state == S_ACCESS && idx != 2'd3) begin
            wr_start  = 1'b1;
            wr_offset = write_offset(next_idx);
            case (next_idx)
                2'd1:    wr_data = AMBA_WORD'(width_q);
                2'd2:    wr_data = AMBA_WORD'(noise_q);
                default: wr_data = AMBA_WORD'(op_q);
            endcase
        end
    end

    ecc_apb_write_port #(
        .ADDR_WIDTH(AMBA_ADDR_WIDTH),
        .DATA_WIDTH(AMBA_WORD)
    ) u_write_port (
        .clk    (clk),
        .rst    (rst),
        .start  (wr_start),
        .addr   (AMBA_ADDR_WIDTH'(wr_offset)),
        .data   (wr_data),
        .done   (wr_done),
        .psel   (PSEL),
        .penable(PENABLE),
        .pwrite (PWRITE),
        .paddr  (PADDR),
        .pwdata (PWDATA)
    );

    // Job FSM: accept, four ordered writes, wait for done or timeout, hold the response until taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            tcnt       <= '0;
            op_q       <= 2'd0;
            width_q    <= 2'd0;
            noise_q    <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_errors <= 2'd0;
            rsp_status <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        width_q   <= req_width;
                        noise_q   <= req_noise;
                        idx       <= 2'd0;
                        if (req_op == OP_ILLEGAL) begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= '0;
                            rsp_errors <= 2'd0;
                            rsp_status <= STATUS_ILLEGAL;
                        end else begin
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: state <= S_ACCESS;
                S_ACCESS: begin
                    if (wr_done) begin
                        if (idx == 2'd3) begin
                            state <= S_WAIT_DONE;
                            tcnt  <= '0;
                        end else begin
                            idx   <= next_idx;
                            state <= S_SETUP;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (operation_done) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= data_out;
                        rsp_errors <= num_of_errors;
                        rsp_status <= STATUS_OK;
                    end else if (tcnt == TLAST) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= '0;
                        rsp_errors <= 2'd0;
                        rsp_status <= STATUS_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb/tb_ecc_apb_sequencer.sv - directed self-checking bench for ecc_apb_sequencer
module tb_ecc_apb_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic [1:0]  req_width;
    logic [31:0] req_noise;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors;
    logic [1:0]  rsp_status;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic        PSEL;
    logic        PWRITE;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    ecc_apb_sequencer #(
        .DATA_WIDTH     (32),
        .AMBA_ADDR_WIDTH(20),
        .AMBA_WORD      (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_data      (req_data),
        .req_width     (req_width),
        .req_noise     (req_noise),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_errors    (rsp_errors),
        .rsp_status    (rsp_status),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PENABLE       (PENABLE),
        .PSEL          (PSEL),
        .PWRITE        (PWRITE),
        .data_out      (data_out),
        .operation_done(operation_done),
        .num_of_errors (num_of_errors),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input logic [19:0] a, input logic [31:0] d);
        check("setup_psel", PSEL, 1);
        check("setup_penable", PENABLE, 0);
        check("setup_pwrite", PWRITE, 1);
        check("setup_paddr", PADDR, a);
        check("setup_pwdata", PWDATA, d);
        @(negedge clk);
        check("access_psel", PSEL, 1);
        check("access_penable", PENABLE, 1);
        check("access_pwrite", PWRITE, 1);
        check("access_paddr", PADDR, a);
        check("access_pwdata", PWDATA, d);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [1:0] w, input logic [31:0] n);
        check("accept_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_width = w;
        req_noise = n;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = 32'hFFFF_FFFF;
        req_noise = 32'hFFFF_FFFF;
        req_width = 2'd3;
        req_op    = 2'd3;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_data = '0; req_width = 2'd0;
        req_noise = '0; rsp_ready = 1'b0; data_out = '0; operation_done = 1'b0; num_of_errors = 2'd0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_errors", rsp_errors, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", req_ready, 1);

        // encode job, done at T+12
        issue(2'd0, 32'h0000_00A5, 2'd0, 32'h0000_0100);
        check("enc_busy", busy, 1);
        check("enc_ready_low", req_ready, 0);
        check_write(20'h04, 32'h0000_00A5);
        check_write(20'h08, 32'h0);
        check_write(20'h0C, 32'h0000_0100);
        check_write(20'h00, 32'h0);
        check("enc_wait_psel", PSEL, 0);
        check("enc_wait_paddr", PADDR, 0);
        check("enc_wait_busy", busy, 1);
        repeat (3) begin
            @(negedge clk);
            check("enc_wait_no_rsp", rsp_valid, 0);
        end
        operation_done = 1'b1; data_out = 32'hDEAD_BEEF; num_of_errors = 2'd0;
        @(negedge clk);
        operation_done = 1'b0; data_out = '0;
        check("enc_rsp_valid", rsp_valid, 1);
        check("enc_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("enc_rsp_status", rsp_status, 0);
        check("enc_rsp_errors", rsp_errors, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("enc_hs_valid", rsp_valid, 0);
        check("enc_hs_ready", req_ready, 1);
        check("enc_hs_busy", busy, 0);

        // decode job with early done pulse, two errors, stalled response
        issue(2'd1, 32'h1234_5678, 2'd2, 32'h0000_0003);
        check_write(20'h04, 32'h1234_5678);
        operation_done = 1'b1; data_out = 32'h0000_0BAD;
        check_write(20'h08, 32'h2);
        operation_done = 1'b0;
        check_write(20'h0C, 32'h3);
        check_write(20'h00, 32'h1);
        check("dec_no_early_rsp", rsp_valid, 0);
        operation_done = 1'b1; data_out = 32'h1234_5678; num_of_errors = 2'd2;
        @(negedge clk);
        operation_done = 1'b1; data_out = 32'hFFFF_0000; num_of_errors = 2'd1;
        check("dec_rsp_valid", rsp_valid, 1);
        check("dec_rsp_errors", rsp_errors, 2);
        check("dec_rsp_status", rsp_status, 0);
        check("dec_rsp_data", rsp_data, 32'h1234_5678);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, 32'h1234_5678);
            check("stall_errors", rsp_errors, 2);
            check("stall_ready", req_ready, 0);
            check("stall_busy", busy, 1);
        end
        operation_done = 1'b0; num_of_errors = 2'd0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("dec_hs_valid", rsp_valid, 0);
        check("dec_hs_ready", req_ready, 1);

        // full job with no done: timeout at WAIT_DONE entry + 16
        issue(2'd2, 32'h0000_0055, 2'd1, 32'h0);
        check_write(20'h04, 32'h55);
        check_write(20'h08, 32'h1);
        check_write(20'h0C, 32'h0);
        check_write(20'h00, 32'h2);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check("to_pending", rsp_valid, 0);
        end
        @(negedge clk);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_status", rsp_status, 1);
        check("to_rsp_data", rsp_data, 0);
        check("to_rsp_errors", rsp_errors, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // done in the same cycle the timeout expires resolves to done
        issue(2'd0, 32'h0000_0077, 2'd0, 32'h0);
        repeat (8) @(negedge clk);
        repeat (15) @(negedge clk);
        operation_done = 1'b1; data_out = 32'h0000_0077; num_of_errors = 2'd1;
        @(negedge clk);
        operation_done = 1'b0;
        check("race_valid", rsp_valid, 1);
        check("race_status", rsp_status, 0);
        check("race_data", rsp_data, 32'h77);
        check("race_errors", rsp_errors, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // illegal op: immediate response, no APB traffic
        issue(2'd3, 32'h0000_1111, 2'd0, 32'h0);
        check("ill_valid", rsp_valid, 1);
        check("ill_status", rsp_status, 2);
        check("ill_psel", PSEL, 0);
        check("ill_data", rsp_data, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ill_hs_psel", PSEL, 0);
        check("ill_hs_ready", req_ready, 1);

        // reset during NOISE ACCESS, then a clean job
        issue(2'd1, 32'h0000_00F0, 2'd1, 32'h0000_0008);
        check_write(20'h04, 32'hF0);
        check_write(20'h08, 32'h1);
        check("mid_noise_setup", PADDR, 20'h0C);
        @(negedge clk);
        check("mid_noise_access", PENABLE, 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_psel", PSEL, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_paddr", PADDR, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        issue(2'd0, 32'h0000_0042, 2'd3, 32'h0000_0009);
        check_write(20'h04, 32'h42);
        check_write(20'h08, 32'h3);
        check_write(20'h0C, 32'h9);
        check_write(20'h00, 32'h0);
        operation_done = 1'b1; data_out = 32'h0000_0C42; num_of_errors = 2'd0;
        @(negedge clk);
        operation_done = 1'b0;
        check("post_rsp_valid", rsp_valid, 1);
        check("post_rsp_data", rsp_data, 32'h0C42);
        check("post_rsp_status", rsp_status, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
